// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: buffer state encoding, widths, entry record.
// Pure declarations; no latency or backpressure of its own.
package wb_port_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } pend_ent_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back, MDU, decode-lookup and register-file write bundle around the arbiter.
// slave = arbiter side, master = pipeline/bench side.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic              wb_we;
    logic [ADDR_W-1:0] wb_rw;
    logic [DATA_W-1:0] wb_busw;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_rw;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              pend_hit;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rw;
    logic [DATA_W-1:0] rf_busw;

    modport slave (
        input  wb_we, wb_rw, wb_busw, mdu_valid, mdu_rw, mdu_data, rs_addr, rt_addr,
        output mdu_ready, pend_hit, rf_we, rf_rw, rf_busw
    );

    modport master (
        output wb_we, wb_rw, wb_busw, mdu_valid, mdu_rw, mdu_data, rs_addr, rt_addr,
        input  mdu_ready, pend_hit, rf_we, rf_rw, rf_busw
    );

endinterface

// File: rtl/wb_pend_buf.sv
// Two-entry FIFO of deferred MDU writes; pipeline writes to a buffered register mark it dead.
// Enqueue/drain take effect at the next edge; ready drops when both entries are occupied.
module wb_pend_buf
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [ADDR_W-1:0] enq_rw,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    input  logic              kill,
    input  logic [ADDR_W-1:0] kill_rw,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output buf_state_t        state,
    output pend_ent_t         head,
    output logic              ready,
    output logic              pend_hit
);

    pend_ent_t [1:0] ent_q;
    pend_ent_t [1:0] ent_n;
    buf_state_t      state_n;
    logic [1:0]      cnt;
    logic [1:0]      occ;

    assign cnt   = state;
    assign occ   = cnt - {1'b0, deq};
    assign head  = ent_q[0];
    assign ready = (int'(cnt) < DEPTH);

    // Kill applies to entries already held; an entry enqueued this cycle is newer and stays live.
    always_comb begin
        ent_n = ent_q;
        for (int i = 0; i < 2; i++) begin
            if (kill && ent_n[i].live && ent_n[i].rw == kill_rw) begin
                ent_n[i].live = 1'b0;
            end
        end
        if (deq) begin
            ent_n[0] = ent_n[1];
            ent_n[1] = '0;
        end
        if (enq) begin
            ent_n[occ[0]] = '{live: 1'b1, rw: enq_rw, data: enq_data};
        end
        state_n = buf_state_t'(occ + {1'b0, enq});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ent_q <= '0;
        end else begin
            state <= state_n;
            ent_q <= ent_n;
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ent_q[i].live &&
                ((rs_addr != ZERO_REG && ent_q[i].rw == rs_addr) ||
                 (rt_addr != ZERO_REG && ent_q[i].rw == rt_addr))) begin
                pend_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline wins, MDU bypasses when idle or queues; 1-cycle registered write.
// Backpressure via mdu_ready (low when two MDU writes are queued); WB_ARB_STATS_EN adds conflict_cnt.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef WB_ARB_STATS_EN
    output logic [15:0]        conflict_cnt,
`endif
    wb_port_arbiter_if.slave   bus
);

    buf_state_t        buf_state;
    pend_ent_t         head;
    logic              buf_ready;
    logic              pipe_wr;
    logic              mdu_wr;
    logic              bypass;
    logic              enq;
    logic              drain;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_rw;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_rw_q;
    logic [DATA_W-1:0] rf_busw_q;

    assign pipe_wr = bus.wb_we && (bus.wb_rw != ZERO_REG);
    // Accepted MDU results for r0 complete the handshake but are dropped.
    assign mdu_wr  = bus.mdu_valid && buf_ready && (bus.mdu_rw != ZERO_REG);
    assign drain   = !pipe_wr && (buf_state != EMPTY);
    assign bypass  = mdu_wr && !pipe_wr && (buf_state == EMPTY);
    assign enq     = mdu_wr && !bypass;

    wb_pend_buf #(.DEPTH(DEPTH)) u_pend_buf (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .enq_rw   (bus.mdu_rw),
        .enq_data (bus.mdu_data),
        .deq      (drain),
        .kill     (pipe_wr),
        .kill_rw  (bus.wb_rw),
        .rs_addr  (bus.rs_addr),
        .rt_addr  (bus.rt_addr),
        .state    (buf_state),
        .head     (head),
        .ready    (buf_ready),
        .pend_hit (bus.pend_hit)
    );

    assign bus.mdu_ready = buf_ready;

    always_comb begin
        sel_we   = 1'b0;
        sel_rw   = bus.wb_rw;
        sel_data = bus.wb_busw;
        if (pipe_wr) begin
            sel_we = 1'b1;
        end else if (drain) begin
            sel_we   = head.live;
            sel_rw   = head.rw;
            sel_data = head.data;
        end else if (bypass) begin
            sel_we   = 1'b1;
            sel_rw   = bus.mdu_rw;
            sel_data = bus.mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_rw_q   <= ZERO_REG;
            rf_busw_q <= '0;
        end else begin
            rf_we_q <= sel_we;
            if (sel_we) begin
                rf_rw_q   <= sel_rw;
                rf_busw_q <= sel_data;
            end
        end
    end

    assign bus.rf_we   = rf_we_q;
    assign bus.rf_rw   = rf_rw_q;
    assign bus.rf_busw = rf_busw_q;

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 16'h0000;
        end else if (pipe_wr && bus.mdu_valid && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector table plus reset sequence for wb_port_arbiter; expected rf writes go through a scoreboard queue.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef WB_ARB_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rw;
        logic [31:0] wb_busw;
        logic        mdu_valid;
        logic [4:0]  mdu_rw;
        logic [31:0] mdu_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        exp_ready;
        logic        exp_hit;
        logic        exp_we;
        logic [4:0]  exp_rw;
        logic [31:0] exp_busw;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
    } rf_exp_t;

    vec_t    vecs[$];
    rf_exp_t sb[$];
    int      checks   = 0;
    int      failures = 0;
    logic [4:0]  last_rw   = 5'd0;
    logic [31:0] last_busw = 32'd0;

    function automatic vec_t mk(int wbwe, int wbrw, int wbd, int mv, int mrw, int md,
                                int rs, int rt, int rdy, int hit, int we, int erw, int ed);
        vec_t v;
        v.wb_we     = 1'(wbwe);
        v.wb_rw     = 5'(wbrw);
        v.wb_busw   = 32'(wbd);
        v.mdu_valid = 1'(mv);
        v.mdu_rw    = 5'(mrw);
        v.mdu_data  = 32'(md);
        v.rs        = 5'(rs);
        v.rt        = 5'(rt);
        v.exp_ready = 1'(rdy);
        v.exp_hit   = 1'(hit);
        v.exp_we    = 1'(we);
        v.exp_rw    = 5'(erw);
        v.exp_busw  = 32'(ed);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rf();
        rf_exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("rf_we", 32'(bus.rf_we), 32'(e.we));
            chk("rf_rw", 32'(bus.rf_rw), 32'(e.rw));
            chk("rf_busw", bus.rf_busw, e.busw);
        end
    endtask

    task automatic drive_idle(input logic [4:0] rs, input logic [4:0] rt);
        bus.wb_we = 1'b0; bus.wb_rw = 5'd0; bus.wb_busw = 32'd0;
        bus.mdu_valid = 1'b0; bus.mdu_rw = 5'd0; bus.mdu_data = 32'd0;
        bus.rs_addr = rs; bus.rt_addr = rt;
    endtask

    // Each step: compare the write registered at the previous edge, then apply the next vector.
    task automatic step(input vec_t v);
        rf_exp_t e;
        @(negedge clk);
        if (sb.size() > 0) check_rf();
        bus.wb_we = v.wb_we; bus.wb_rw = v.wb_rw; bus.wb_busw = v.wb_busw;
        bus.mdu_valid = v.mdu_valid; bus.mdu_rw = v.mdu_rw; bus.mdu_data = v.mdu_data;
        bus.rs_addr = v.rs; bus.rt_addr = v.rt;
        #1;
        chk("mdu_ready", 32'(bus.mdu_ready), 32'(v.exp_ready));
        chk("pend_hit", 32'(bus.pend_hit), 32'(v.exp_hit));
        if (v.exp_we) begin
            last_rw   = v.exp_rw;
            last_busw = v.exp_busw;
        end
        e.we   = v.exp_we;
        e.rw   = last_rw;
        e.busw = last_busw;
        sb.push_back(e);
    endtask

    task automatic flush();
        @(negedge clk);
        check_rf();
        drive_idle(5'd0, 5'd0);
    endtask

    initial begin
        drive_idle(5'd0, 5'd0);
        // wbwe wbrw wbd      mv mrw md      rs rt rdy hit we erw ed
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 'h1234,  0, 0, 0,       0, 0,  1, 0, 1, 8, 'h1234));
        vecs.push_back(mk(1, 5, 'hA,     1, 6, 'hB,     6, 0,  1, 0, 1, 5, 'hA));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       6, 0,  1, 1, 1, 6, 'hB));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       6, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 'hC,    1, 11, 'hD,    0, 0,  1, 0, 1, 10, 'hC));
        vecs.push_back(mk(1, 12, 'hE,    1, 13, 'hF,    0, 11, 1, 1, 1, 12, 'hE));
        vecs.push_back(mk(1, 14, 'h10,   1, 15, 'h99,   13, 0, 0, 1, 1, 14, 'h10));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 1, 11, 'hD));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 1, 13, 'hF));
        vecs.push_back(mk(0, 0, 0,       1, 16, 'h20,   0, 0,  1, 0, 1, 16, 'h20));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       16, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h30,    1, 9, 'h1,     0, 0,  1, 0, 1, 1, 'h30));
        vecs.push_back(mk(1, 9, 'h2,     0, 0, 0,       9, 0,  1, 1, 1, 9, 'h2));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       9, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 20, 'h40,   1, 20, 'h41,   0, 0,  1, 0, 1, 20, 'h40));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       20, 0, 1, 1, 1, 20, 'h41));
        vecs.push_back(mk(1, 0, 'h50,    1, 0, 'h51,    0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 'h60,    1, 3, 'h61,    0, 0,  1, 0, 1, 2, 'h60));
        vecs.push_back(mk(0, 0, 0,       1, 4, 'h62,    4, 0,  1, 0, 1, 3, 'h61));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 4,  1, 1, 1, 4, 'h62));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 25, 'h80,   1, 26, 'h81,   0, 0,  1, 0, 1, 25, 'h80));
        vecs.push_back(mk(1, 0, 'h82,    0, 0, 0,       26, 0, 1, 1, 1, 26, 'h81));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       26, 0, 1, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset_rf_rw", 32'(bus.rf_rw), 32'd0);
        chk("reset_rf_busw", bus.rf_busw, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) step(vecs[i]);
        flush();

        // Fill both entries, then reset mid-operation.
        step(mk(1, 21, 'h70, 1, 22, 'h71, 0, 0,  1, 0, 1, 21, 'h70));
        step(mk(1, 23, 'h72, 1, 24, 'h73, 22, 0, 1, 1, 1, 23, 'h72));
        @(negedge clk);
        check_rf();
        drive_idle(5'd22, 5'd24);
        #1;
        chk("full_ready", 32'(bus.mdu_ready), 32'd0);
        chk("full_hit", 32'(bus.pend_hit), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_rw", 32'(bus.rf_rw), 32'd0);
        chk("rst_rf_busw", bus.rf_busw, 32'd0);
        chk("rst_ready", 32'(bus.mdu_ready), 32'd1);
        chk("rst_hit", 32'(bus.pend_hit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
            chk("post_rst_hit", 32'(bus.pend_hit), 32'd0);
            chk("post_rst_ready", 32'(bus.mdu_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, number of buffer entries for multi-cycle-unit writes; 2 is the only supported value.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 wb_we  in  1  write enable from the pipeline write-back stage, already masked by overflow and RegWr.
REQ-005 wb_rw  in  5  destination register from write-back (31 for Jal).
REQ-006 wb_busw  in  32  write-back data (PC+4, Dout or Result).
REQ-007 mdu_valid  in  1  multi-cycle unit (mult/div) result valid.
REQ-008 mdu_rw  in  5  MDU destination register.
REQ-009 mdu_data  in  32  MDU result.
REQ-010 mdu_ready  out  1  the arbiter accepts the MDU result this cycle.
REQ-011 rs_addr, rt_addr  in  5 each  decode-stage read addresses.
REQ-012 pend_hit  out  1  a live buffered entry targets rs_addr or rt_addr (nonzero); drives the hazard-unit stall.
REQ-013 rf_we  out  1  registered register-file write enable.
REQ-014 rf_rw  out  5  registered write address.
REQ-015 rf_busw  out  32  registered write data.

Function
REQ-016 Every write reaches rf_* exactly one cycle after it is selected (registered output, latency 1).
REQ-017 The pipeline has absolute priority: a cycle with wb_we=1 and wb_rw!=0 selects the pipeline write.
REQ-018 A write with address 0 is discarded and never produces rf_we=1.
REQ-019 The MDU handshake completes in a cycle where mdu_valid and mdu_ready are both 1; mdu_ready = (count<2), combinational from state only.
REQ-020 Buffer states: EMPTY, ONE, TWO; FIFO order; the head drains in any cycle with no pipeline write.
REQ-021 In EMPTY with no pipeline write, an accepted MDU result is selected directly that cycle and is not buffered.
REQ-022 Otherwise an accepted MDU result is enqueued at the tail.
REQ-023 Simultaneous drain and enqueue keeps count unchanged (ONE->ONE, TWO->TWO not possible since ready=0 in TWO).
REQ-024 Transitions: EMPTY->ONE on enqueue without bypass; ONE->TWO on enqueue without drain; ONE->EMPTY on drain without enqueue; TWO->ONE on drain.
REQ-025 Kill: a pipeline write whose wb_rw matches a live buffered entry marks that entry dead (the newer pipeline value wins); a dead entry drains without asserting rf_we.
REQ-026 An MDU result accepted in the same cycle as a pipeline write to the same register is enqueued live (MDU is newer).
REQ-027 pend_hit is combinational over live entries only; dead entries and address 0 never hit.
REQ-028 With no selected write, rf_we=0 and rf_rw/rf_busw hold their previous values.

Reset
REQ-029 On rst: state EMPTY, all entries dead, rf_we=0, rf_rw=0, rf_busw=0, mdu_ready=1 after release.
REQ-030 Reset mid-operation discards buffered entries without writing them.

Configuration
REQ-031 WB_ARB_STATS_EN defined: adds output conflict_cnt (16 bits), incremented in each cycle with wb_we=1, wb_rw!=0 and mdu_valid=1; saturates at 16'hFFFF; reset to 0.
REQ-032 WB_ARB_STATS_EN undefined: no counter and no port; all other behaviour is identical.

Structure
REQ-033 A shared package holds the buffer-state encoding (EMPTY=0, ONE=1, TWO=2), the register-address width (5), the data width (32) and the zero-register constant.
REQ-034 The two-entry buffer with kill logic is a sub-module, wb_pend_buf; selection and output registers stay in the top.

Verification
REQ-035 Pipeline only: wb_we=1, wb_rw=8, wb_busw=32'h1234 -> next cycle rf_we=1, rf_rw=8, rf_busw=32'h1234.
REQ-036 Conflict: in the same cycle wb (rw=5, 32'hA) and mdu (rw=6, 32'hB) -> cycle+1 writes r5=A; the first idle cycle after that writes r6=B at the following edge.
REQ-037 Full: two conflicting MDU results buffered -> mdu_ready=0; one idle cycle -> mdu_ready=1 and the head is written.
REQ-038 Kill: MDU r9=32'h1 buffered, then pipeline writes r9=32'h2 -> the r9 drain produces no rf_we; the final value of r9 is 32'h2; pend_hit for rs=9 drops after the kill.
REQ-039 Address 0: wb_rw=0 with wb_we=1, and mdu_rw=0 -> rf_we never asserted; pend_hit=0.
REQ-040 Reset asserted with TWO live entries -> rf_we=0 immediately, no pending writes after release, mdu_ready=1.
